// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer writer.
// Holds the FSM state enum, default geometry and the slot-base helper.
package fb_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  localparam int IMG_W_DEF  = 256;
  localparam int IMG_H_DEF  = 256;
  localparam int ADDR_W_DEF = 18;

  // First RAM word of an image slot; slots are packed back to back.
  function automatic logic [31:0] slot_base(input logic [1:0] sel,
                                            input int img_w,
                                            input int img_h);
    return 32'(sel) * 32'(img_w) * 32'(img_h);
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Raster x/y counters for the frame-buffer writer; produces the full-width
// RAM address of the current pixel and a flag marking the last pixel.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic [1:0]        i_base_sel,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_x_wrap;
  logic          w_y_wrap;

  assign w_x_wrap = (r_x == X_MAX);
  assign w_y_wrap = (r_y == Y_MAX);

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (w_x_wrap) begin
        r_x <= '0;
        r_y <= w_y_wrap ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Sum is formed at full ADDR_W width; four slots always fit the address space.
  assign o_addr = ADDR_W'(slot_base(i_base_sel, IMG_W, IMG_H))
                + ADDR_W'(r_y) * ADDR_W'(IMG_W)
                + ADDR_W'(r_x);
  assign o_last = w_x_wrap && w_y_wrap;

endmodule

// File: rtl/fb_writer.sv
// Frame-buffer fill stage: writes a valid/ready pixel stream in raster order
// into one of four RAM image slots. Optional checksum: FB_WRITER_CHECKSUM_EN.
module fb_writer
  import fb_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        base_sel,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [7:0]        data,
  output logic              wren,
  output logic              busy,
`ifdef FB_WRITER_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic              done
);

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_base_sel;
  logic              w_accept;
  logic              w_start_acc;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_wraddress;
  logic [7:0]        r_data;
  logic              r_wren;
  logic              r_busy;
  logic              r_done;

  fb_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_start_acc),
    .i_advance  (w_accept),
    .i_base_sel (r_base_sel),
    .o_addr     (w_addr),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start)             w_state_next = S_FILL;
      S_FILL: if (w_accept && w_last) w_state_next = S_IDLE;
      default:                       w_state_next = S_IDLE;
    endcase
  end

  // in_ready depends on state only, never on in_valid.
  always_comb begin
    in_ready    = (r_state == S_FILL);
    w_accept    = in_valid && in_ready;
    w_start_acc = (r_state == S_IDLE) && start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base_sel  <= '0;
      r_wren      <= 1'b0;
      r_wraddress <= '0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_start_acc) r_base_sel <= base_sel;
      r_wren <= w_accept;
      if (w_accept) begin
        r_wraddress <= w_addr;
        r_data      <= in_data;
      end
      r_busy <= (w_state_next == S_FILL);
      r_done <= w_accept && w_last;
    end
  end

  assign wren      = r_wren;
  assign wraddress = r_wraddress;
  assign data      = r_data;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef FB_WRITER_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk) begin
    if (reset || w_start_acc) r_checksum <= '0;
    else if (w_accept)        r_checksum <= r_checksum + 16'(in_data);
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer at IMG_W=4, IMG_H=2 with a frame-level
// reference model; honours FB_WRITER_CHECKSUM_EN for the checksum output.
module tb_fb_writer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 18;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    base_sel = 2'd0;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] wraddress;
  logic [7:0]    data;
  logic          wren;
  logic          busy;
  logic          done;
`ifdef FB_WRITER_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  always #5 clk = ~clk;

  fb_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_sel  (base_sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wraddress (wraddress),
    .data      (data),
    .wren      (wren),
    .busy      (busy),
`ifdef FB_WRITER_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .done      (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Frame-level reference: in_frame flag, pixel count, slot number.
  bit            m_ok   = 1'b0;
  bit            m_fill = 1'b0;
  bit            m_wren = 1'b0;
  bit            m_done = 1'b0;
  int            m_k    = 0;
  int            m_base = 0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_data = '0;
  logic [15:0]   m_cs   = '0;

  int         wq_addr[$];
  int         wq_cyc[$];
  logic [7:0] wq_data[$];
  int         n_busy = 0;
  int         n_done = 0;
  int         last_done_cyc = -1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_ok = 1'b1; m_fill = 1'b0; m_wren = 1'b0; m_done = 1'b0;
      m_addr = '0; m_data = '0; m_cs = '0; m_k = 0;
    end else begin
      m_wren = 1'b0;
      m_done = 1'b0;
      if (m_fill) begin
        if (in_valid) begin
          m_wren = 1'b1;
          m_addr = AW'(m_base * NPIX + m_k);
          m_data = in_data;
          m_cs   = m_cs + 16'(in_data);
          m_k++;
          if (m_k == NPIX) begin
            m_fill = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (start) begin
        m_fill = 1'b1;
        m_base = int'(base_sel);
        m_k    = 0;
        m_cs   = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("in_ready",  32'(in_ready),  32'(m_fill));
      chk("wren",      32'(wren),      32'(m_wren));
      chk("wraddress", 32'(wraddress), 32'(m_addr));
      chk("data",      32'(data),      32'(m_data));
      chk("busy",      32'(busy),      32'(m_fill));
      chk("done",      32'(done),      32'(m_done));
`ifdef FB_WRITER_CHECKSUM_EN
      chk("checksum",  32'(checksum),  32'(m_cs));
`endif
      if (wren === 1'b1) begin
        wq_addr.push_back(int'(wraddress));
        wq_data.push_back(data);
        wq_cyc.push_back(cyc);
      end
      if (busy === 1'b1) n_busy++;
      if (done === 1'b1) begin
        n_done++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 full rate, 1 valid every other cycle, 2 random valid.
  // dmode: 0 d0+i, 1 random, 2 constant d0.
  task automatic run_frame(input logic [1:0] b, input int vmode, input bit ign,
                           input int dmode, input logic [7:0] d0, output int first_idx);
    int         i = 0;
    int         g = 0;
    int         nd0;
    bit         acc;
    logic [7:0] sent[NPIX];
    start = 1'b1;
    base_sel = b;
    tick();
    start = 1'b0;
    base_sel = ~b;
    first_idx = wq_addr.size();
    nd0 = n_done;
    while (i < NPIX && g < 200) begin
      in_valid = (vmode == 0) || (vmode == 1 && (g % 2) == 0) ||
                 (vmode == 2 && $urandom_range(1) == 1);
      in_data  = (dmode == 0) ? d0 + 8'(i) : (dmode == 1) ? 8'($urandom) : d0;
      start    = ign && (i == 2 || i == 5);
      acc = in_valid && in_ready;
      if (acc) sent[i] = in_data;
      tick();
      if (acc) i++;
      g++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("frame_beats", 32'(i), 32'(NPIX));
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_in_ready", 32'(in_ready), 32'd0);
    chk("end_wren", 32'(wren), 32'd1);
    chk("end_addr", 32'(wraddress), 32'(int'(b) * NPIX + NPIX - 1));
    chk("frame_done_pulses", 32'(n_done - nd0), 32'd0);
    chk("frame_writes", 32'(wq_addr.size() - first_idx), 32'(NPIX - 1));
    for (int k = 0; k < NPIX - 1; k++) begin
      if (first_idx + k < wq_addr.size()) begin
        chk("frame_addr", 32'(wq_addr[first_idx + k]), 32'(int'(b) * NPIX + k));
        chk("frame_data", 32'(wq_data[first_idx + k]), 32'(sent[k]));
      end
    end
  endtask

  int fi;
  int fi2;
  int nb0;
  int nd_before;
  int qs;
  int dc;

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_wren", 32'(wren), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_addr", 32'(wraddress), 32'd0);
    end
    in_valid = 1'b0;
    tick();

    // Full-rate fill of slot 0 with 0x10..0x17.
    nb0 = n_busy;
    nd_before = n_done;
    run_frame(2'd0, 0, 1'b0, 0, 8'h10, fi);
    tick();
    chk("full_busy_cycles", 32'(n_busy - nb0), 32'd8);
    chk("full_done_count", 32'(n_done - nd_before), 32'd1);
    chk("full_last_data", 32'(wq_data[wq_data.size() - 1]), 32'h17);
    chk("full_first_addr", 32'(wq_addr[fi]), 32'd0);
    chk("full_contiguous", 32'(wq_cyc[wq_cyc.size() - 1] - wq_cyc[fi]), 32'd7);
`ifdef FB_WRITER_CHECKSUM_EN
    chk("full_checksum", 32'(checksum), 32'h009C);
`endif

    // Slot 3 with every-other-cycle valid.
    nd_before = n_done;
    run_frame(2'd3, 1, 1'b0, 1, 8'h00, fi);
    tick();
    chk("stall_done_count", 32'(n_done - nd_before), 32'd1);
    chk("stall_last_addr", 32'(wq_addr[wq_addr.size() - 1]), 32'd31);

    // Start pulses mid-frame are ignored.
    run_frame(2'd1, 0, 1'b1, 0, 8'h40, fi);
    tick();
    chk("ignstart_last_addr", 32'(wq_addr[wq_addr.size() - 1]), 32'd15);

    // Back-to-back: second start in the done cycle.
    run_frame(2'd2, 0, 1'b0, 0, 8'h80, fi);
    run_frame(2'd0, 0, 1'b0, 0, 8'hA0, fi2);
    dc = last_done_cyc;
    chk("b2b_gap", 32'(wq_cyc[fi2] - dc), 32'd2);
    chk("b2b_first_addr", 32'(wq_addr[fi2]), 32'd0);
    tick();

    // Reset during the 5th beat abandons the frame.
    start = 1'b1;
    base_sel = 2'd0;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    qs = wq_addr.size();
    repeat (3) tick();
    chk("rst_no_writes", 32'(wq_addr.size() - qs), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick();
    run_frame(2'd0, 0, 1'b0, 2, 8'hFF, fi);
`ifdef FB_WRITER_CHECKSUM_EN
    chk("ff_checksum", 32'(checksum), 32'h07F8);
`endif
    tick();

    // Randomized frames: random slot, random valid, random data, random ignored starts.
    for (int r = 0; r < 12; r++) begin
      run_frame(2'($urandom_range(3)), 2, 1'($urandom_range(1)), 1, 8'h00, fi);
      repeat ($urandom_range(2)) tick();
    end
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
